alu_serial_ctrl: RTL and testbench
==================================

Name: alu_serial_ctrl

Overview:
- Sequencer that drives one 1-bit ALU slice (3-bit op code, B invert, carry in/out, less/lessunsigned inputs) bit-serially, LSB first, to compute one WIDTH-bit result per request.
- Latches the operands, steps the slice once per clock and holds the carry between bits.
- Resolves SLT/SLTU after the MSB, then presents the result and flags with a start/done handshake.
- Sits between the decode/control unit and the register-file write-back in the monocycle core's serial-ALU option.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), width of the bit-index counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- start_i  input  1  request; accepted only when ready_o=1.
- op_i  input  3  operation: 000 ADD, 001 AND, 010 OR, 011 XOR, 100 SUB, 101 SLT, 110 SLTU, 111 ZERO.
- a_i  input  WIDTH  operand A; sampled on the accepting edge.
- b_i  input  WIDTH  operand B; sampled on the accepting edge.
- ready_o  output  1  controller idle; can accept start_i.
- done_o  output  1  one-cycle pulse; result_o and flags valid.
- result_o  output  WIDTH  result; held until the next accepted start.
- cout_o  output  1  final carry out (ADD/SUB/SLT/SLTU), else 0.
- ovf_o  output  1  signed overflow (ADD/SUB only), else 0.
- zero_o  output  1  result_o == 0.

Behaviour:
- Reset: state IDLE; ready_o=1; done_o=0; result_o, cout_o, ovf_o=0; zero_o=1; bit counter=0; carry register=0.
- FSM IDLE:
  - When start_i=1, latch a_i, b_i, op_i, clear the bit counter, load the carry seed, go to RUN.
  - When start_i=0, stay in IDLE.
- FSM RUN:
  - Each cycle, apply bit k of A and B to the slice. Write the slice output to result bit k. Register the slice carry out as the carry for bit k+1.
  - At k=WIDTH-1, go to DONE.
- FSM DONE:
  - done_o=1 for exactly this cycle; ready_o=0.
  - Next state is always IDLE. start_i in DONE is ignored, not queued.
- Latency: start accepted at edge T -> bits 0..WIDTH-1 processed in cycles T+1..T+WIDTH -> done_o=1 in cycle T+WIDTH+1 -> ready_o=1 in cycle T+WIDTH+2. No back-to-back overlap.
- ready_o=1 only in IDLE. Operand inputs are don't-care outside the accepting edge.
- Slice drive per op:
  - ADD: slice op 000, invert 0, carry seed 0.
  - SUB: slice op 100, invert 1, carry seed 1.
  - AND/OR/XOR: slice op 001/010/011, invert 0, carry seed 0; cout_o, ovf_o forced 0.
  - SLT/SLTU: run as SUB during RUN. Serial bits are not kept; result_o is overwritten in DONE.
  - ZERO: slice op 111; result 0.
  - Slice less_i and lessunsigned_i are tied 0 and unused in serial mode.
- Overflow: ovf_o = carry into MSB XOR carry out of MSB, both captured at k=WIDTH-1.
- SLT result: {0, (sum[MSB] XOR ovf)}.
- SLTU result: {0, ~cout}. cout_o still reports the raw carry.
- zero_o is computed from the final result_o, including the SLT/SLTU overwrite.
- Flags update only in DONE and hold with result_o until the next DONE.
- Reset mid-operation returns to IDLE with reset values; any partial result is discarded and no done_o pulse occurs.
- Counter never wraps: it is compared to WIDTH-1 and is never incremented past it.

Test Plan:
- Reset, then ADD a=0x0000_0005, b=0x0000_0003 -> done_o at T+33, result_o=0x0000_0008, cout_o=0, zero_o=0, ready_o=1 at T+34.
- ADD a=0xFFFF_FFFF, b=0x0000_0001 -> result_o=0, cout_o=1, zero_o=1, ovf_o=0. Then SUB a=0x8000_0000, b=1 -> result_o=0x7FFF_FFFF, ovf_o=1, cout_o=1.
- SLT a=0xFFFF_FFFF (-1), b=1 -> result_o=1. SLTU, same operands -> result_o=0, cout_o=1. SLT a=5, b=5 -> result_o=0, zero_o=1.
- AND/OR/XOR a=0xF0F0_1234, b=0x0FF0_FFFF -> 0x00F0_1234, 0xFFF0_FFFF, 0xFF00_EDCB; cout_o=0, ovf_o=0. ZERO op -> result_o=0, zero_o=1.
- start_i held high continuously with changing operands -> only the first request is accepted; second request accepted in the IDLE cycle after DONE; operand changes during RUN do not alter the result.
- rst_i asserted at cycle T+10 of a SUB -> next cycle IDLE, ready_o=1, result_o=0, no done_o. A fresh ADD 2+2 then yields 4 with normal latency.

Source files
------------

// File: rtl/alu_serial_ctrl_if.sv
// Request/result bundle between decode/control and the serial ALU sequencer.
// The master raises start_i with operands; the slave answers with ready/done and the result flags.
interface alu_serial_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             ready_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             cout_o;
  logic             ovf_o;
  logic             zero_o;

  modport master (
    output start_i, op_i, a_i, b_i,
    input  ready_o, done_o, result_o, cout_o, ovf_o, zero_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i,
    output ready_o, done_o, result_o, cout_o, ovf_o, zero_o
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Drives a 1-bit ALU slice LSB first; done_o pulses WIDTH+1 cycles after the accepting edge.
// ready_o is high only in IDLE; start_i is ignored while RUN/DONE, so requests are never queued.
module alu_serial_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic              clk_i,
  input logic              rst_i,
  alu_serial_ctrl_if.slave bus
);
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_ready;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [2:0]       w_slice_op;
  logic             w_binv;
  logic             w_a_bit;
  logic             w_b_eff;
  logic             w_sum;
  logic             w_cout;
  logic             w_bit;
  logic             w_less;
  logic             w_lessu;
  logic             w_last;
  logic             w_ovf;
  logic             w_arith;
  logic             w_addsub;
  logic [WIDTH-1:0] w_final;

  // Set-less-than ops run through the slice as a plain subtract.
  always_comb begin
    w_slice_op = r_op;
    w_binv     = 1'b0;
    if (r_op == OP_SUB || r_op == OP_SLT || r_op == OP_SLTU) begin
      w_slice_op = OP_SUB;
      w_binv     = 1'b1;
    end
  end

  assign w_less  = 1'b0;
  assign w_lessu = 1'b0;
  assign w_a_bit = r_a[r_cnt];
  assign w_b_eff = r_b[r_cnt] ^ w_binv;
  assign w_sum   = w_a_bit ^ w_b_eff ^ r_carry;
  assign w_cout  = (w_a_bit & w_b_eff) | (r_carry & (w_a_bit ^ w_b_eff));

  always_comb begin
    case (w_slice_op)
      3'b000, 3'b100: w_bit = w_sum;
      3'b001:         w_bit = w_a_bit & w_b_eff;
      3'b010:         w_bit = w_a_bit | w_b_eff;
      3'b011:         w_bit = w_a_bit ^ w_b_eff;
      3'b101:         w_bit = w_less;
      3'b110:         w_bit = w_lessu;
      default:        w_bit = 1'b0;
    endcase
  end

  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_ovf    = r_carry ^ w_cout;
  assign w_arith  = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_SLT) || (r_op == OP_SLTU);
  assign w_addsub = (r_op == OP_ADD) || (r_op == OP_SUB);

  // Final word as seen on the MSB step, with the compare ops collapsed to 0/1.
  always_comb begin
    w_final            = r_acc;
    w_final[WIDTH-1]   = w_bit;
    if (r_op == OP_SLT) begin
      w_final = {{(WIDTH-1){1'b0}}, w_bit ^ w_ovf};
    end else if (r_op == OP_SLTU) begin
      w_final = {{(WIDTH-1){1'b0}}, ~w_cout};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_op     <= OP_ADD;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_a     <= bus.a_i;
            r_b     <= bus.b_i;
            r_op    <= bus.op_i;
            r_cnt   <= '0;
            r_carry <= (bus.op_i == OP_SUB) || (bus.op_i == OP_SLT) || (bus.op_i == OP_SLTU);
            r_ready <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc[r_cnt] <= w_bit;
          r_carry      <= w_cout;
          if (w_last) begin
            r_result <= w_final;
            r_cout   <= w_arith & w_cout;
            r_ovf    <= w_addsub & w_ovf;
            r_zero   <= (w_final == '0);
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o  = r_ready;
  assign bus.done_o   = r_done;
  assign bus.result_o = r_result;
  assign bus.cout_o   = r_cout;
  assign bus.ovf_o    = r_ovf;
  assign bus.zero_o   = r_zero;

  // OP_AND/OP_OR/OP_XOR are decoded by the slice case via their raw codes.
  logic w_unused_ops;
  assign w_unused_ops = ^{OP_AND, OP_OR, OP_XOR};
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl: arithmetic/logic/compare vectors, held start, mid-run reset.
module tb_alu_serial_ctrl;
  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_ZERO = 3'b111;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  alu_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

  alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Counts edges until done_o is seen; gives up at 40 so a hung DUT shows as a latency error.
  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done_o !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ec,
                        input logic eo, input logic ez);
    int lat;
    chk({tag, "_rdy_pre"}, bus.ready_o, 1);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    tick();
    bus.start_i = 1'b0;
    bus.op_i    = ~op;
    bus.a_i     = ~a;
    bus.b_i     = ~b;
    chk({tag, "_rdy_busy"}, bus.ready_o, 0);
    wait_done(lat);
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_rdy_done"}, bus.ready_o, 0);
    chk({tag, "_res"}, bus.result_o, er);
    chk({tag, "_cout"}, bus.cout_o, ec);
    chk({tag, "_ovf"}, bus.ovf_o, eo);
    chk({tag, "_zero"}, bus.zero_o, ez);
    tick();
    chk({tag, "_done_pulse"}, bus.done_o, 0);
    chk({tag, "_rdy_post"}, bus.ready_o, 1);
    chk({tag, "_res_hold"}, bus.result_o, er);
  endtask

  initial begin
    int lat;
    logic seen_done;
    rst_i       = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = OP_ADD;
    bus.a_i     = '0;
    bus.b_i     = '0;
    repeat (3) tick();
    chk("rst_rdy", bus.ready_o, 1);
    chk("rst_done", bus.done_o, 0);
    chk("rst_res", bus.result_o, 0);
    chk("rst_cout", bus.cout_o, 0);
    chk("rst_ovf", bus.ovf_o, 0);
    chk("rst_zero", bus.zero_o, 1);
    rst_i = 1'b0;
    tick();

    run_op("add_5_3",   OP_ADD,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap",  OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("sub_ovf",   OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_op("slt_neg",   OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    run_op("sltu_big",  OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("slt_eq",    OP_SLT,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("and",       OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0, 1'b0);
    run_op("or",        OP_OR,   32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("xor",       OP_XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 1'b0, 1'b0);
    run_op("zero",      OP_ZERO, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1);

    // start_i stays high throughout: one request per IDLE visit, operand churn during RUN ignored.
    bus.start_i = 1'b1;
    bus.op_i    = OP_ADD;
    bus.a_i     = 32'd10;
    bus.b_i     = 32'd20;
    tick();
    bus.a_i = 32'd100;
    bus.b_i = 32'd200;
    chk("hold_rdy_busy", bus.ready_o, 0);
    wait_done(lat);
    chk("hold1_lat", lat, LAT);
    chk("hold1_res", bus.result_o, 32'd30);
    tick();
    chk("hold_idle_rdy", bus.ready_o, 1);
    chk("hold_idle_done", bus.done_o, 0);
    tick();
    bus.start_i = 1'b0;
    chk("hold2_rdy_busy", bus.ready_o, 0);
    wait_done(lat);
    chk("hold2_lat", lat, LAT);
    chk("hold2_res", bus.result_o, 32'd300);
    tick();

    // Reset sampled at the tenth edge after acceptance of a SUB.
    seen_done   = 1'b0;
    bus.start_i = 1'b1;
    bus.op_i    = OP_SUB;
    bus.a_i     = 32'h0000_0100;
    bus.b_i     = 32'h0000_0001;
    tick();
    bus.start_i = 1'b0;
    repeat (9) begin
      tick();
      if (bus.done_o === 1'b1) seen_done = 1'b1;
    end
    rst_i = 1'b1;
    tick();
    chk("midrst_rdy", bus.ready_o, 1);
    chk("midrst_res", bus.result_o, 0);
    chk("midrst_done", bus.done_o, 0);
    chk("midrst_zero", bus.zero_o, 1);
    rst_i = 1'b0;
    repeat (40) begin
      tick();
      if (bus.done_o === 1'b1) seen_done = 1'b1;
    end
    chk("midrst_no_done", seen_done, 0);
    run_op("add_after_rst", OP_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
